// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC generation, single-outstanding imem fetch over req/gnt/rvalid,
//            and a prefetch FIFO feeding the datapath via valid/ready.
//            Optional macro IFU_BYPASS_EN: combinational rvalid-to-inst bypass
//            when the FIFO is empty.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [15:0]                   redirect_pc,
    output logic                          imem_req,
    output logic [15:0]                   imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [15:0]                   imem_rdata,
    output logic                          inst_valid,
    output logic [15:0]                   inst_data,
    output logic [15:0]                   inst_pc,
    input  logic                          inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                 c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]      c_depth    = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [15:0]        c_reset_pc = {RESET_PC[15:1], 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            r_state_q,    w_state_d;
    logic [15:0]       r_fetch_pc_q, w_fetch_pc_d;
    logic [15:0]       r_req_pc_q,   w_req_pc_d;
    logic [c_aw-1:0]   r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_aw-1:0]   r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_aw:0]     r_count_q,    w_count_d;
    logic [31:0]       r_mem_q [FIFO_DEPTH];

    logic [31:0]       w_head;
    logic              w_fifo_vld;
    logic              w_bypass;
    logic              w_pop;
    logic              w_rsp;
    logic              w_push;
    logic [15:0]       w_redirect_pc;
    logic              w_unused;

    // Instruction addresses are halfword aligned; bit 0 is deliberately dropped.
    assign w_unused      = redirect_pc[0];
    assign w_redirect_pc = {redirect_pc[15:1], 1'b0};

    assign imem_req   = (r_state_q == S_REQ);
    assign imem_addr  = r_fetch_pc_q;
    assign fifo_count = r_count_q;

    // ------------------------------------------------------------------
    // Datapath-facing outputs and FIFO handshake qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        w_head     = r_mem_q[r_rd_ptr_q];
        w_fifo_vld = (r_count_q != '0);
`ifdef IFU_BYPASS_EN
        w_bypass   = (r_state_q == S_WAIT) && !w_fifo_vld && !redirect_valid;
`else
        w_bypass   = 1'b0;
`endif
        if (w_bypass) begin
            inst_valid = imem_rvalid;
            inst_data  = imem_rvalid ? imem_rdata : 16'h0000;
            inst_pc    = imem_rvalid ? r_req_pc_q : 16'h0000;
        end else begin
            inst_valid = w_fifo_vld;
            inst_data  = w_fifo_vld ? w_head[15:0]  : 16'h0000;
            inst_pc    = w_fifo_vld ? w_head[31:16] : 16'h0000;
        end

        // A redirect flushes everything, so neither pop nor push may land.
        w_pop  = w_fifo_vld && inst_ready && !redirect_valid;
        w_rsp  = (r_state_q == S_WAIT) && imem_rvalid && !redirect_valid;
        w_push = w_rsp && !(w_bypass && inst_ready);
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_count_d  = r_count_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        if (redirect_valid) begin
            w_count_d  = '0;
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_aw'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + (c_aw + 1)'(1);
                2'b01:   w_count_d = r_count_q - (c_aw + 1)'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_fetch_pc_d = r_fetch_pc_q;
        w_req_pc_d   = r_req_pc_q;
        case (r_state_q)
            S_IDLE: begin
                if (!redirect_valid && ((r_count_q < c_depth) || w_pop)) begin
                    w_state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_state_d = imem_gnt ? S_DROP : S_IDLE;
                end else if (imem_gnt) begin
                    w_req_pc_d   = r_fetch_pc_q;
                    w_fetch_pc_d = r_fetch_pc_q + 16'd2;
                    w_state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_d = S_IDLE;
                end else if (redirect_valid) begin
                    w_state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The stale response retires the only outstanding fetch, even
                // when a second redirect coincides with it.
                if (imem_rvalid) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_fetch_pc_d = w_redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_fetch_pc_q <= c_reset_pc;
            r_req_pc_q   <= 16'h0000;
            r_rd_ptr_q   <= '0;
            r_wr_ptr_q   <= '0;
            r_count_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_fetch_pc_q <= w_fetch_pc_d;
            r_req_pc_q   <= w_req_pc_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_count_q    <= w_count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_wr_ptr_q] <= {r_req_pc_q, imem_rdata};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit with a simple
//            instruction memory model (data = addr ^ 16'h5A5A).
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata  = 16'h0000;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    logic        gnt_en;
    int          rsp_delay;
    logic        use_dead;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          age = 0;
    int          dead_seen = 0;

    logic [15:0] req_q [$];
    logic [31:0] dlv_q [$];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    assign imem_gnt = imem_req & gnt_en;

    // Memory model and observers: bookkeeping at the edge, response driven
    // at the falling edge so it is stable for the next rising edge.
    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (imem_rvalid) begin
                pend = 1'b0;
            end else if (pend) begin
                age = age + 1;
            end
            if (imem_req && imem_gnt) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                age       = 1;
                req_q.push_back(imem_addr);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                dlv_q.push_back({inst_pc, inst_data});
            end
            if (inst_valid && inst_data == 16'hDEAD) begin
                dead_seen = dead_seen + 1;
            end
        end
    end

    always @(negedge clk) begin
        imem_rvalid = pend && (age >= rsp_delay);
        if (!imem_rvalid) begin
            imem_rdata = 16'h0000;
        end else if (use_dead && pend_addr == 16'h0000) begin
            imem_rdata = 16'hDEAD;
        end else begin
            imem_rdata = pend_addr ^ 16'h5A5A;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] req_at(input int i);
        return (req_q.size() > i) ? req_q[i] : 16'hBAD1;
    endfunction

    function automatic logic [31:0] dlv_at(input int i);
        return (dlv_q.size() > i) ? dlv_q[i] : 32'hBAD1_BAD1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb;
        int db;
        int dead_base;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        inst_ready = 1'b1; gnt_en = 1'b1; rsp_delay = 1; use_dead = 1'b0;
        step(); step();

        // Reset state
        check_eq("rst_imem_req",   imem_req,   0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst_data",  inst_data,  0);
        check_eq("rst_inst_pc",    inst_pc,    0);
        check_eq("rst_fifo_count", fifo_count, 0);

        // Streaming fetch, immediate gnt, rvalid one cycle later
        rb = req_q.size(); db = dlv_q.size();
        rst = 1'b0;
        step();
        check_eq("t1_first_req",  imem_req,  1);
        check_eq("t1_first_addr", imem_addr, 16'h0000);
        repeat (15) step();
        check_eq("t1_req0", req_at(rb),     16'h0000);
        check_eq("t1_req1", req_at(rb + 1), 16'h0002);
        check_eq("t1_req2", req_at(rb + 2), 16'h0004);
        check_eq("t1_dlv0", dlv_at(db),     32'h0000_5A5A);
        check_eq("t1_dlv1", dlv_at(db + 1), 32'h0002_5A58);
        check_eq("t1_dlv2", dlv_at(db + 2), 32'h0004_5A5E);

        // Back-pressure fills the FIFO, one pop releases one more fetch
        rst = 1'b1; inst_ready = 1'b0;
        step(); step();
        rb = req_q.size();
        rst = 1'b0;
        repeat (25) step();
        check_eq("t2_nreq",      req_q.size() - rb, 4);
        check_eq("t2_req3",      req_at(rb + 3), 16'h0006);
        check_eq("t2_count",     fifo_count, 4);
        check_eq("t2_req_idle",  imem_req,   0);
        check_eq("t2_valid",     inst_valid, 1);
        check_eq("t2_head_pc",   inst_pc,    16'h0000);
        check_eq("t2_head_data", inst_data,  16'h5A5A);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("t2_pop_pc",    inst_pc,    16'h0002);
        check_eq("t2_pop_count", fifo_count, 3);
        check_eq("t2_req5",      imem_req,   1);
        check_eq("t2_addr5",     imem_addr,  16'h0008);
        repeat (6) step();
        check_eq("t2_req4_log",  req_at(rb + 4), 16'h0008);
        check_eq("t2_refill",    fifo_count, 4);

        // Redirect while waiting on a slow response that must be discarded
        rst = 1'b1; inst_ready = 1'b1; rsp_delay = 3; use_dead = 1'b1;
        step(); step();
        dead_base = dead_seen;
        rst = 1'b0;
        step();
        check_eq("t3_in_req",  imem_req,  1);
        step();
        check_eq("t3_in_wait", imem_req,  0);
        redirect_valid = 1'b1; redirect_pc = 16'h0041;
        step();
        redirect_valid = 1'b0;
        check_eq("t3_count0",  fifo_count, 0);
        check_eq("t3_no_req",  imem_req,   0);
        rb = req_q.size(); db = dlv_q.size();
        repeat (20) step();
        use_dead = 1'b0;
        check_eq("t3_no_dead", dead_seen - dead_base, 0);
        check_eq("t3_req0",    req_at(rb), 16'h0040);
        check_eq("t3_dlv0",    dlv_at(db), 32'h0040_5A1A);

        // Wrap of the fetch PC across 16'hFFFE
        rst = 1'b1; rsp_delay = 1;
        step(); step();
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        rb = req_q.size(); db = dlv_q.size();
        step();
        redirect_valid = 1'b0;
        repeat (12) step();
        check_eq("t4_req0", req_at(rb),     16'hFFFE);
        check_eq("t4_req1", req_at(rb + 1), 16'h0000);
        check_eq("t4_dlv0", dlv_at(db),     32'hFFFE_A5A4);
        check_eq("t4_dlv1", dlv_at(db + 1), 32'h0000_5A5A);

        // Redirect coinciding with a pop and a push
        rst = 1'b1; inst_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_rvalid && fifo_count != 0) break;
            step();
        end
        check_eq("t5_setup", {31'd0, imem_rvalid && fifo_count != 0}, 1);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        check_eq("t5_count0", fifo_count, 0);
        check_eq("t5_valid0", inst_valid, 0);
        rb = req_q.size(); db = dlv_q.size();
        inst_ready = 1'b1;
        repeat (12) step();
        check_eq("t5_req0", req_at(rb), 16'h0100);
        check_eq("t5_dlv0", dlv_at(db), 32'h0100_5B5A);

        // Reset asserted while a request is pending without grant
        rst = 1'b1; inst_ready = 1'b0; gnt_en = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fifo_count == 2) break;
            step();
        end
        check_eq("t6_fill2", fifo_count, 2);
        gnt_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) break;
            step();
        end
        check_eq("t6_in_req", imem_req, 1);
        step();
        check_eq("t6_req_held",  imem_req,  1);
        check_eq("t6_addr_held", imem_addr, 16'h0004);
        rst = 1'b1;
        step();
        check_eq("t6_rst_req",   imem_req,   0);
        check_eq("t6_rst_valid", inst_valid, 0);
        check_eq("t6_rst_count", fifo_count, 0);
        gnt_en = 1'b1;
        rb = req_q.size();
        rst = 1'b0;
        repeat (6) step();
        check_eq("t6_req_reset_pc", req_at(rb), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the datapath: generates the PC, fetches 16-bit instructions from instruction memory over a req/gnt/rvalid handshake, and buffers them in a small prefetch FIFO.
- Presents instructions and their PCs to the datapath with a valid/ready handshake.
- Datapath-issued redirects (jump, beq/bne taken) flush the FIFO and discard any in-flight fetch.

Parameters:
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  load redirect_pc and flush this cycle.
- redirect_pc  input  16  new fetch address; bit 0 ignored and forced to 0.
- imem_req  output  1  fetch request.
- imem_addr  output  16  fetch byte address; always even.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  16  instruction word.
- inst_valid  output  1  instruction available to the datapath.
- inst_data  output  16  instruction; opcode in [15:12].
- inst_pc  output  16  byte address of inst_data.
- inst_ready  input  1  datapath consumes the instruction when inst_valid && inst_ready.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, fifo_count=0.
  - rst has priority over all other inputs, including mid-fetch. A response for a request outstanding at reset is ignored; memory must complete or abandon it.
- States: IDLE, REQ, WAIT, DROP. At most one fetch is outstanding.
- IDLE:
  - Go to REQ if fifo_count < FIFO_DEPTH, or if a pop occurs this cycle.
  - First imem_req therefore asserts one cycle after reset release.
- REQ:
  - imem_req=1 and imem_addr=fetch_pc, both held stable until imem_gnt.
  - On gnt: latch req_pc=fetch_pc, set fetch_pc=fetch_pc+2 (16-bit wrap: 16'hFFFE to 16'h0000), go to WAIT.
- WAIT:
  - imem_rvalid may arrive no earlier than the cycle after gnt.
  - On rvalid: push {req_pc, imem_rdata} into the FIFO, go to IDLE.
  - A slot is always free because the request was only issued when one was free.
- DROP:
  - On rvalid: discard the data, go to IDLE.
- inst_data and inst_pc show the FIFO head; both read 0 when empty.
- Without bypass, inst_valid rises the cycle after rvalid.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- Full FIFO: no request issued. inst_valid is held until inst_ready.
- Redirect (redirect_valid=1 at an edge): FIFO flushed to count 0, fetch_pc=redirect_pc, and any pop that cycle is ignored. Per state:
  - IDLE: go to IDLE.
  - REQ without gnt: imem_req is withdrawn and state goes to IDLE; the new request is issued the next cycle. Memory must tolerate a non-granted request being dropped.
  - REQ with gnt: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: data discarded, go to IDLE.
  - DROP: stay in DROP with the new PC.
- A redirect and a push in the same cycle: the flush wins.

Optional Feature:
- Macro: IFU_BYPASS_EN.
- Defined:
  - In WAIT with the FIFO empty, inst_valid=imem_rvalid, inst_data=imem_rdata and inst_pc=req_pc, all combinational.
  - If inst_ready is also high, the word is consumed without being written to the FIFO, giving zero added latency.
  - Not applied in DROP or in a redirect cycle.
- Undefined: responses always pass through the FIFO, so there is one cycle of rvalid-to-inst_valid latency and no combinational path from imem to inst.

Test Plan:
- Reset release, memory with gnt immediate and rvalid 1 cycle later, inst_ready=1 -> addresses 0000, 0002, 0004 requested in order; inst_pc matches each; inst_data equals the memory word.
- inst_ready=0, FIFO_DEPTH=4 -> exactly 4 fetches (0000-0006) complete, fifo_count=4, imem_req stays 0; then one pop -> next request for 0008.
- Redirect to 16'h0040 while in WAIT, rvalid 3 cycles later with 16'hDEAD -> DEAD never appears on inst_data; next request is 0040; fifo_count=0 the cycle after the redirect.
- redirect_pc=16'hFFFE -> fetches FFFE then 0000; inst_pc sequence FFFE, 0000.
- Redirect in the same cycle as inst_valid && inst_ready and a push -> FIFO empty afterwards; the first delivered instruction has inst_pc=redirect_pc.
- rst asserted in REQ with imem_req=1 -> next cycle imem_req=0, inst_valid=0, fifo_count=0; the first request after release is to RESET_PC.
